tlb_write_ctrl: RTL and testbench

- Executes committed TLBWR and TLBFILL instructions; the write-direction counterpart of the TLBRD path that loads TLBELO0/TLBELO1/TLBEHI/TLBIDX from the TLB.
- Snapshots the CSR images (TLBIDX, TLBEHI, TLBELO0, TLBELO1, ASID) and selects the target entry.
- Drives a single-cycle write port into the TLB array.
- Sits between the commit stage and the TLB array, beside the CSR file.

---
 rtl/tlb_write_ctrl.sv | 165 ++++++++++++++++
 tb/tb_tlb_write_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_write_ctrl.sv
// tlb_write_ctrl: executes committed TLBWR/TLBFILL, snapshots CSR images
// and drives a single-cycle write port into the TLB array.
// Ports:
//   clk, rst (async, active-high)
//   TLBWR_req, TLBFILL_req : one-cycle commit pulses
//   TLBIDX, TLBEHI, TLBELO0, TLBELO1, ASID, tlbr_state : CSR images
//   busy, done : handshake back to commit
//   tlb_we, tlb_w_* : TLB array write port (registered, held until next capture)
// Optional macro TLBFILL_LFSR_EN: fill index from a 16-bit LFSR instead
// of the round-robin counter.
module tlb_write_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int INDEX_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               TLBWR_req,
    input  logic               TLBFILL_req,
    input  logic [31:0]        TLBIDX,
    input  logic [31:0]        TLBEHI,
    input  logic [31:0]        TLBELO0,
    input  logic [31:0]        TLBELO1,
    input  logic [9:0]         ASID,
    input  logic               tlbr_state,
    output logic               busy,
    output logic               done,
    output logic               tlb_we,
    output logic [INDEX_W-1:0] tlb_w_index,
    output logic               tlb_w_e,
    output logic [18:0]        tlb_w_vppn,
    output logic [5:0]         tlb_w_ps,
    output logic [9:0]         tlb_w_asid,
    output logic               tlb_w_g,
    output logic [19:0]        tlb_w_ppn0,
    output logic [19:0]        tlb_w_ppn1,
    output logic [5:0]         tlb_w_flags0,
    output logic [5:0]         tlb_w_flags1
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_cap;
    logic               w_fill_sel;
    logic [INDEX_W-1:0] w_fill_idx;
    logic               w_unused;

    // TLBWR has priority; a simultaneous TLBFILL is dropped entirely.
    assign w_fill_sel = TLBFILL_req & ~TLBWR_req;

    assign w_unused = &{1'b0, TLBIDX[30], TLBIDX[23:INDEX_W],
                        TLBEHI[12:0], TLBELO0[31:28], TLBELO0[7],
                        TLBELO1[31:28], TLBELO1[7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        tlb_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (TLBWR_req || TLBFILL_req) begin
                    w_cap  = 1'b1;
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                tlb_we = 1'b1;
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                busy   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

`ifdef TLBFILL_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    // Fibonacci LFSR, taps 16,14,13,11 in right-shift form.
    assign w_fb       = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_fill_idx = r_lfsr[INDEX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end
`else
    logic [INDEX_W-1:0] r_fill_cnt;
    logic               r_is_fill;

    assign w_fill_idx = r_fill_cnt;

    // Counter advances only once the fill has actually completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt <= '0;
            r_is_fill  <= 1'b0;
        end else begin
            if (w_cap) begin
                r_is_fill <= w_fill_sel;
            end
            if (r_state == S_DONE && r_is_fill) begin
                if (r_fill_cnt == INDEX_W'(TLB_ENTRIES - 1)) begin
                    r_fill_cnt <= '0;
                end else begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tlb_w_index  <= '0;
            tlb_w_e      <= 1'b0;
            tlb_w_vppn   <= '0;
            tlb_w_ps     <= '0;
            tlb_w_asid   <= '0;
            tlb_w_g      <= 1'b0;
            tlb_w_ppn0   <= '0;
            tlb_w_ppn1   <= '0;
            tlb_w_flags0 <= '0;
            tlb_w_flags1 <= '0;
        end else if (w_cap) begin
            tlb_w_index  <= w_fill_sel ? w_fill_idx : TLBIDX[INDEX_W-1:0];
            // Refill handler always writes a valid entry regardless of NE.
            tlb_w_e      <= tlbr_state ? 1'b1 : ~TLBIDX[31];
            tlb_w_vppn   <= TLBEHI[31:13];
            tlb_w_ps     <= TLBIDX[29:24];
            tlb_w_asid   <= ASID;
            tlb_w_g      <= TLBELO0[6] & TLBELO1[6];
            tlb_w_ppn0   <= TLBELO0[27:8];
            tlb_w_ppn1   <= TLBELO1[27:8];
            tlb_w_flags0 <= TLBELO0[5:0];
            tlb_w_flags1 <= TLBELO1[5:0];
        end
    end

endmodule

// File: tb/tb_tlb_write_ctrl.sv
// tb_tlb_write_ctrl: directed self-checking bench for tlb_write_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_tlb_write_ctrl;

    logic        clk;
    logic        rst;
    logic        TLBWR_req;
    logic        TLBFILL_req;
    logic [31:0] TLBIDX;
    logic [31:0] TLBEHI;
    logic [31:0] TLBELO0;
    logic [31:0] TLBELO1;
    logic [9:0]  ASID;
    logic        tlbr_state;
    logic        busy;
    logic        done;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic        tlb_w_e;
    logic [18:0] tlb_w_vppn;
    logic [5:0]  tlb_w_ps;
    logic [9:0]  tlb_w_asid;
    logic        tlb_w_g;
    logic [19:0] tlb_w_ppn0;
    logic [19:0] tlb_w_ppn1;
    logic [5:0]  tlb_w_flags0;
    logic [5:0]  tlb_w_flags1;

    int n_vec = 0;
    int n_err = 0;

    tlb_write_ctrl #(.TLB_ENTRIES(16), .INDEX_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .TLBWR_req    (TLBWR_req),
        .TLBFILL_req  (TLBFILL_req),
        .TLBIDX       (TLBIDX),
        .TLBEHI       (TLBEHI),
        .TLBELO0      (TLBELO0),
        .TLBELO1      (TLBELO1),
        .ASID         (ASID),
        .tlbr_state   (tlbr_state),
        .busy         (busy),
        .done         (done),
        .tlb_we       (tlb_we),
        .tlb_w_index  (tlb_w_index),
        .tlb_w_e      (tlb_w_e),
        .tlb_w_vppn   (tlb_w_vppn),
        .tlb_w_ps     (tlb_w_ps),
        .tlb_w_asid   (tlb_w_asid),
        .tlb_w_g      (tlb_w_g),
        .tlb_w_ppn0   (tlb_w_ppn0),
        .tlb_w_ppn1   (tlb_w_ppn1),
        .tlb_w_flags0 (tlb_w_flags0),
        .tlb_w_flags1 (tlb_w_flags1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse request for one cycle; returns at the negedge of the WRITE cycle.
    task automatic issue(input logic wr, input logic fill);
        TLBWR_req   = wr;
        TLBFILL_req = fill;
        @(negedge clk);
        TLBWR_req   = 1'b0;
        TLBFILL_req = 1'b0;
    endtask

    // From the WRITE cycle, step through DONE back to IDLE.
    task automatic finish_op(input string tag);
        @(negedge clk);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_we_off"}, {31'b0, tlb_we}, 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    int          n_we;
    logic [15:0] lfsr_m;

    initial begin
        rst         = 1'b1;
        TLBWR_req   = 1'b0;
        TLBFILL_req = 1'b0;
        TLBIDX      = '0;
        TLBEHI      = '0;
        TLBELO0     = '0;
        TLBELO1     = '0;
        ASID        = '0;
        tlbr_state  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_we", {31'b0, tlb_we}, 32'd0);
        chk("rst_fields", {tlb_w_index, tlb_w_e, tlb_w_vppn, tlb_w_ps},
            32'd0);
        chk("rst_ppn", {12'b0, tlb_w_ppn0 | tlb_w_ppn1}, 32'd0);
        rst = 1'b0;

        // Basic TLBWR
        TLBIDX  = 32'h0C00_0005;
        TLBEHI  = 32'h1234_6000;
        TLBELO0 = 32'h0012_3457;
        TLBELO1 = 32'h0045_6613;
        ASID    = 10'h2A;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        issue(1'b1, 1'b0);
        chk("wr_we", {31'b0, tlb_we}, 32'd1);
        chk("wr_busy", {31'b0, busy}, 32'd1);
        chk("wr_done0", {31'b0, done}, 32'd0);
        chk("wr_index", {28'b0, tlb_w_index}, 32'd5);
        chk("wr_e", {31'b0, tlb_w_e}, 32'd1);
        chk("wr_ps", {26'b0, tlb_w_ps}, 32'h0C);
        chk("wr_vppn", {13'b0, tlb_w_vppn}, 32'h091A3);
        chk("wr_ppn0", {12'b0, tlb_w_ppn0}, 32'h01234);
        chk("wr_flags0", {26'b0, tlb_w_flags0}, 32'h17);
        chk("wr_ppn1", {12'b0, tlb_w_ppn1}, 32'h04566);
        chk("wr_flags1", {26'b0, tlb_w_flags1}, 32'h13);
        chk("wr_g", {31'b0, tlb_w_g}, 32'd0);
        chk("wr_asid", {22'b0, tlb_w_asid}, 32'h2A);
        TLBEHI = 32'hFFFF_E000;
        finish_op("wr");
        chk("wr_hold_vppn", {13'b0, tlb_w_vppn}, 32'h091A3);

        // G set only when both halves have G
        TLBELO1 = 32'h0045_6653;
        issue(1'b1, 1'b0);
        chk("g_both", {31'b0, tlb_w_g}, 32'd1);
        chk("g_vppn_new", {13'b0, tlb_w_vppn}, 32'h7FFFF);
        finish_op("g");

        // NE handling
        TLBIDX = 32'h8C00_0003;
        issue(1'b1, 1'b0);
        chk("ne_e0", {31'b0, tlb_w_e}, 32'd0);
        chk("ne_index", {28'b0, tlb_w_index}, 32'd3);
        finish_op("ne0");
        tlbr_state = 1'b1;
        issue(1'b1, 1'b0);
        chk("ne_tlbr_e1", {31'b0, tlb_w_e}, 32'd1);
        finish_op("ne1");
        tlbr_state = 1'b0;

`ifndef TLBFILL_LFSR_EN
        // Round-robin fill sequence from reset
        do_reset();
        TLBIDX = 32'h0C00_0007;
        for (int i = 0; i < 18; i++) begin
            issue(1'b0, 1'b1);
            chk($sformatf("fill%0d_idx", i), {28'b0, tlb_w_index},
                32'(i % 16));
            chk($sformatf("fill%0d_we", i), {31'b0, tlb_we}, 32'd1);
            finish_op($sformatf("fill%0d", i));
        end

        // Simultaneous requests: TLBWR wins, counter untouched
        do_reset();
        TLBIDX = 32'h0C00_0009;
        issue(1'b1, 1'b1);
        chk("both_idx", {28'b0, tlb_w_index}, 32'd9);
        finish_op("both");
        chk("both_we_after", {31'b0, tlb_we}, 32'd0);
        issue(1'b0, 1'b1);
        chk("both_next_fill", {28'b0, tlb_w_index}, 32'd0);
        finish_op("both_fill");
`endif

        // Requests while busy are ignored
        TLBIDX = 32'h0C00_0002;
        issue(1'b1, 1'b0);
        TLBWR_req = 1'b1;
        TLBIDX    = 32'h0C00_000E;
        @(negedge clk);
        chk("busy_done", {31'b0, done}, 32'd1);
        chk("busy_we", {31'b0, tlb_we}, 32'd0);
        @(negedge clk);
        TLBWR_req = 1'b0;
        chk("busy_idle", {31'b0, busy}, 32'd0);
        n_we = 0;
        repeat (3) begin
            @(negedge clk);
            if (tlb_we) n_we++;
        end
        chk("busy_no_extra_we", 32'(n_we), 32'd0);
        chk("busy_index_kept", {28'b0, tlb_w_index}, 32'd2);

        // Reset during WRITE aborts immediately
        issue(1'b1, 1'b0);
        chk("abort_pre_we", {31'b0, tlb_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we", {31'b0, tlb_we}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_index", {28'b0, tlb_w_index}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        n_we = 0;
        repeat (4) begin
            @(negedge clk);
            if (tlb_we || done) n_we++;
        end
        chk("abort_no_write", 32'(n_we), 32'd0);

`ifdef TLBFILL_LFSR_EN
        // LFSR fill: request after three advances from the seed
        do_reset();
        repeat (3) @(negedge clk);
        lfsr_m = 16'hACE1;
        repeat (3) lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5],
                             lfsr_m[15:1]};
        issue(1'b0, 1'b1);
        chk("lfsr_idx", {28'b0, tlb_w_index}, {28'b0, lfsr_m[3:0]});
        chk("lfsr_idx_c", {28'b0, tlb_w_index}, 32'hC);
        finish_op("lfsr");
`else
        lfsr_m = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
